kairo_fetch: RTL and testbench
==============================

KAIRO_FETCH -- requirements
Module: kairo_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port I_MEM_REQ, output, 1 bit: fetch request valid.
REQ-005 The block SHALL have port I_MEM_ADDR, output, 32 bits: fetch address, bits [1:0] always 0.
REQ-006 The block SHALL have port I_MEM_READY, input, 1 bit: memory accepts the request this cycle.
REQ-007 The block SHALL have port I_MEM_RVALID, input, 1 bit: read data valid; exactly one per accepted request, returned in order, at least 1 cycle after acceptance.
REQ-008 The block SHALL have port I_MEM_RDATA, input, 32 bits: instruction word.
REQ-009 The block SHALL have port REDIRECT, input, 1 bit: a taken branch, jump, trap or MRET.
REQ-010 The block SHALL have port REDIRECT_PC, input, 32 bits: the new fetch address; bits [1:0] are ignored and treated as 0.
REQ-011 The block SHALL have port STALL, input, 1 bit: the decode stage cannot accept an instruction.
REQ-012 The block SHALL have port INST_VALID, output, 1 bit: INST_CODE and INST_PC are valid.
REQ-013 The block SHALL have port INST_CODE, output, 32 bits: instruction presented to decode.
REQ-014 The block SHALL have port INST_PC, output, 32 bits: the address of INST_CODE.

Function
REQ-015 The block SHALL hold a fetch PC register; an accepted request (I_MEM_REQ & I_MEM_READY) SHALL advance it by 4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-016 I_MEM_ADDR SHALL equal the fetch PC.
REQ-017 I_MEM_REQ SHALL equal (outstanding + fifo_count < 4) & ~REDIRECT, where outstanding is 0..4 and is not reduced by a same-cycle pop or return.
REQ-018 While I_MEM_REQ is high and I_MEM_READY is low, I_MEM_ADDR SHALL stay stable unless REDIRECT occurs.
REQ-019 The block SHALL contain a 4-entry {PC, instruction} FIFO; an I_MEM_RVALID that is not discarded SHALL push {PC of the matching request, I_MEM_RDATA}.
REQ-020 The PC of each outstanding request SHALL be tracked in order, e.g. by a 4-entry PC queue or a response-PC counter.
REQ-021 INST_VALID SHALL equal FIFO non-empty & ~REDIRECT; INST_CODE and INST_PC SHALL be the FIFO head.
REQ-022 When INST_VALID is low, INST_CODE SHALL be 32'h0000_0013 (NOP) and INST_PC SHALL be 0.
REQ-023 Pop SHALL occur when INST_VALID & ~STALL; push and pop in the same cycle SHALL leave the count unchanged.
REQ-024 Latency: an RVALID in cycle n SHALL produce INST_VALID in cycle n+1 when the FIFO was empty (no bypass).
REQ-025 A FIFO push when full SHALL be impossible by the credit rule in REQ-017; an assertion SHALL flag it.
REQ-026 On REDIRECT, the block SHALL, at the next edge:
  - set fetch PC to {REDIRECT_PC[31:2], 2'b00};
  - empty the FIFO;
  - set discard to outstanding - I_MEM_RVALID.
REQ-027 Any RVALID arriving in the REDIRECT cycle SHALL be dropped.
REQ-028 While discard > 0, each RVALID SHALL decrement both discard and outstanding and SHALL NOT push.
REQ-029 New requests after a redirect SHALL issue while discard > 0, subject to REQ-017.
REQ-030 A REDIRECT while discard > 0 SHALL again set discard to outstanding minus the same-cycle return; discard SHALL never exceed outstanding.
REQ-031 STALL SHALL NOT block memory requests; only FIFO occupancy and credits SHALL limit them.
REQ-032 Steady state with 1-cycle memory latency, READY=1 and STALL=0 SHALL sustain one instruction per cycle.

Reset
REQ-033 While RST_N=0, the block SHALL force: fetch PC=RESET_PC, FIFO empty, outstanding=0, discard=0, I_MEM_REQ=0, INST_VALID=0, INST_CODE=32'h0000_0013, INST_PC=0.
REQ-034 I_MEM_REQ SHALL first assert in the first cycle after RST_N rises, with I_MEM_ADDR=RESET_PC.
REQ-035 Reset asserted mid-transaction SHALL abandon all outstanding responses; the memory is reset by the same RST_N.

Verification
REQ-036 Reset release, READY=1, 1-cycle memory returning words 0x00100093, 0x00200113, ... -> INST_VALID from cycle 3 with INST_PC 0,4,8,..., one per cycle.
REQ-037 STALL held high for 10 cycles -> the FIFO fills to 4 and REQ drops; INST_CODE/INST_PC hold. Releasing STALL -> in-order drain with no loss or duplication.
REQ-038 REDIRECT to 0x0000_0102 with 3 requests outstanding -> next request address 0x0000_0100; the 3 stale responses are dropped; the first INST_VALID has INST_PC=0x100.
REQ-039 REDIRECT in the same cycle as RVALID and INST_VALID -> INST_VALID low that cycle; the RVALID is dropped; discard = outstanding - 1.
REQ-040 I_MEM_READY low for 5 cycles with REQ high -> I_MEM_ADDR stable; PC advances only on acceptance; random READY/latency vs. a reference model -> exact instruction stream.
REQ-041 RST_N pulsed low with 2 outstanding -> all outputs at reset values immediately; refetch from RESET_PC.

Source files
------------

// File: rtl/kairo_fetch.sv
// ============================================================================
// kairo_fetch: instruction fetch with 4 request credits, in-order response PC
// tracking, 4-entry {pc, inst} FIFO and redirect with stale-response discard.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module kairo_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        i_mem_req,
    output logic [31:0] i_mem_addr,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst_code,
    output logic [31:0] inst_pc
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] fetch_pc;
    logic [31:0] resp_pc;
    logic [2:0]  outstanding;
    logic [2:0]  discard;
    logic [2:0]  count;
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [31:0] fifo_pc   [4];
    logic [31:0] fifo_code [4];

    logic [3:0]  credit_sum;
    logic [31:0] redirect_base;
    logic        accept;
    logic        dropping;
    logic        push;
    logic        pop;
    logic        unused_low_bits;

    assign redirect_base   = {redirect_pc[31:2], 2'b00};
    assign unused_low_bits = &{1'b0, redirect_pc[1:0]};

    // Credits count requests in flight plus buffered words, using start-of-cycle values.
    assign credit_sum = {1'b0, outstanding} + {1'b0, count};
    assign i_mem_req  = rst_n & (credit_sum < 4'd4) & ~redirect;
    assign i_mem_addr = fetch_pc;
    assign accept     = i_mem_req & i_mem_ready;

    assign dropping   = (discard != 3'd0);
    assign push       = i_mem_rvalid & ~redirect & ~dropping;
    assign inst_valid = (count != 3'd0) & ~redirect;
    assign pop        = inst_valid & ~stall;
    assign inst_code  = inst_valid ? fifo_code[rd_ptr] : NOP;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : 32'h0000_0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= 3'd0;
            discard     <= 3'd0;
        end else begin
            outstanding <= outstanding + {2'b00, accept} - {2'b00, i_mem_rvalid};
            if (redirect) begin
                fetch_pc <= redirect_base;
                resp_pc  <= redirect_base;
                discard  <= outstanding - {2'b00, i_mem_rvalid};
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (dropping && i_mem_rvalid) begin
                    discard <= discard - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else if (redirect) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end

    // Storage needs no reset: occupancy alone qualifies the contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= resp_pc;
            fifo_code[wr_ptr] <= i_mem_rdata;
        end
    end

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && (count == 3'd4))
    );

    a_discard_bounded: assert property (
        @(posedge clk) disable iff (!rst_n) (discard <= outstanding)
    );

endmodule

`default_nettype wire

// File: tb/tb_kairo_fetch.sv
// ============================================================================
// tb_kairo_fetch: directed scenarios against a queued memory model; expected
// instruction streams are sequential PCs with word_at(pc) contents.
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_kairo_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] code;
    logic [31:0] ipc;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 1;
    int mem_due = 0;
    int last_due = 0;

    typedef struct {
        logic [31:0] a;
        int          due;
    } ent_t;
    ent_t pq[$];
    logic [31:0] log_pc[$];
    logic [31:0] log_code[$];

    kairo_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mem_req   (req),
        .i_mem_addr  (addr),
        .i_mem_ready (ready),
        .i_mem_rvalid(rvalid),
        .i_mem_rdata (rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .inst_valid  (valid),
        .inst_code   (code),
        .inst_pc     (ipc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h0010_0093 + (a >> 2) * 32'h0010_0080;
    endfunction

    // Memory: accepts sampled mid-cycle, responses in order, one per cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pq.delete();
                last_due = 0;
            end else if (req && ready) begin
                mem_due = cyc + lat;
                if (mem_due <= last_due) mem_due = last_due + 1;
                last_due = mem_due;
                pq.push_back('{a: addr, due: mem_due});
            end
            @(posedge clk);
            #1;
            cyc++;
            rvalid = 1'b0;
            rdata  = 32'h0;
            if (rst_n && pq.size() > 0 && pq[0].due <= cyc) begin
                rvalid = 1'b1;
                rdata  = word_at(pq[0].a);
                void'(pq.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && valid && !stall) begin
                log_pc.push_back(ipc);
                log_code.push_back(code);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_pc.delete();
        log_code.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", req); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        total++; if (code !== NOP) begin bad++; $display("FAIL reset_code got=%h exp=%h", code, NOP); end
        total++; if (ipc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", ipc); end
        total++; if (addr !== RST_PC) begin bad++; $display("FAIL reset_addr got=%h exp=%h", addr, RST_PC); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        tick();
        rst_n = 1'b1;
        clear_log();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                total++;
                if (req !== 1'b1 || addr !== RST_PC)
                begin bad++; $display("FAIL first_req req=%b addr=%h exp req=1 addr=%h", req, addr, RST_PC); end
            end
            total++;
            if (valid !== (k >= 2)) begin bad++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, valid, (k >= 2)); end
            if (k >= 2) begin
                e = 32'((k - 2) * 4);
                total++;
                if (ipc !== e || code !== word_at(e))
                begin bad++; $display("FAIL stream_inst k=%0d got pc=%h code=%h exp pc=%h code=%h", k, ipc, code, e, word_at(e)); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] hp;
        logic [31:0] hc;
        logic [31:0] e;
        tick();
        stall = 1'b1;
        clear_log();
        @(negedge clk);
        hp = ipc;
        hc = code;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if (valid !== 1'b1 || ipc !== hp || code !== hc)
            begin bad++; $display("FAIL stall_hold k=%0d got v=%b pc=%h code=%h exp v=1 pc=%h code=%h", k, valid, ipc, code, hp, hc); end
        end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL stall_full_req got=%b exp=0", req); end
        total++; if (hc !== word_at(hp)) begin bad++; $display("FAIL stall_head got code=%h exp=%h", hc, word_at(hp)); end
        tick();
        stall = 1'b0;
        repeat (12) @(negedge clk);
        total++; if (log_pc.size() < 10) begin bad++; $display("FAIL stall_drain_count got=%0d exp>=10", log_pc.size()); end
        for (int i = 0; i < log_pc.size(); i++) begin
            e = hp + 32'(4 * i);
            total++;
            if (log_pc[i] !== e || log_code[i] !== word_at(e))
            begin bad++; $display("FAIL stall_drain i=%0d got pc=%h code=%h exp pc=%h", i, log_pc[i], log_code[i], e); end
        end
    endtask

    task automatic test_ready_low();
        logic [31:0] a0;
        logic [31:0] e;
        tick();
        ready = 1'b0;
        @(negedge clk);
        a0 = addr;
        total++; if (req !== 1'b1) begin bad++; $display("FAIL rdylow_req got=%b exp=1", req); end
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            total++;
            if (addr !== a0 || req !== 1'b1)
            begin bad++; $display("FAIL rdylow_stable k=%0d got addr=%h req=%b exp addr=%h req=1", k, addr, req, a0); end
        end
        tick();
        ready = 1'b1;
        clear_log();
        @(negedge clk);
        total++; if (addr !== a0) begin bad++; $display("FAIL rdylow_accept got=%h exp=%h", addr, a0); end
        tick();
        @(negedge clk);
        total++; if (addr !== a0 + 32'd4) begin bad++; $display("FAIL rdylow_advance got=%h exp=%h", addr, a0 + 32'd4); end
        repeat (8) @(negedge clk);
        total++; if (log_pc.size() < 6) begin bad++; $display("FAIL rdylow_count got=%0d exp>=6", log_pc.size()); end
        for (int i = 0; i < log_pc.size(); i++) begin
            e = a0 + 32'(4 * i);
            total++;
            if (log_pc[i] !== e || log_code[i] !== word_at(e))
            begin bad++; $display("FAIL rdylow_stream i=%0d got pc=%h code=%h exp pc=%h", i, log_pc[i], log_code[i], e); end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] e;
        tick();
        ready = 1'b0;
        repeat (10) tick();
        lat = 6;
        ready = 1'b1;
        tick();
        tick();
        tick();
        ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        clear_log();
        @(negedge clk);
        total++;
        if (valid !== 1'b0 || req !== 1'b0 || ipc !== 32'h0 || code !== NOP)
        begin bad++; $display("FAIL redir_cycle got v=%b req=%b pc=%h code=%h exp v=0 req=0 pc=0 code=%h", valid, req, ipc, code, NOP); end
        tick();
        redirect = 1'b0;
        ready = 1'b1;
        lat = 1;
        @(negedge clk);
        total++;
        if (addr !== 32'h0000_0100 || req !== 1'b1)
        begin bad++; $display("FAIL redir_addr got addr=%h req=%b exp addr=00000100 req=1", addr, req); end
        repeat (20) @(negedge clk);
        total++; if (log_pc.size() < 8) begin bad++; $display("FAIL redir_count got=%0d exp>=8", log_pc.size()); end
        for (int i = 0; i < log_pc.size(); i++) begin
            e = 32'h0000_0100 + 32'(4 * i);
            total++;
            if (log_pc[i] !== e || log_code[i] !== word_at(e))
            begin bad++; $display("FAIL redir_stream i=%0d got pc=%h code=%h exp pc=%h", i, log_pc[i], log_code[i], e); end
        end
    endtask

    task automatic test_redirect_rvalid();
        logic [31:0] e;
        repeat (4) tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0203;
        clear_log();
        @(negedge clk);
        total++;
        if (valid !== 1'b0 || req !== 1'b0)
        begin bad++; $display("FAIL rvredir_cycle got v=%b req=%b exp v=0 req=0", valid, req); end
        tick();
        redirect = 1'b0;
        @(negedge clk);
        total++;
        if (addr !== 32'h0000_0200 || valid !== 1'b0)
        begin bad++; $display("FAIL rvredir_next got addr=%h v=%b exp addr=00000200 v=0", addr, valid); end
        tick();
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rvredir_latency got v=%b exp=0", valid); end
        tick();
        @(negedge clk);
        total++;
        if (valid !== 1'b1 || ipc !== 32'h0000_0200 || code !== word_at(32'h0000_0200))
        begin bad++; $display("FAIL rvredir_first got v=%b pc=%h code=%h exp v=1 pc=00000200 code=%h", valid, ipc, code, word_at(32'h0000_0200)); end
        repeat (8) @(negedge clk);
        total++; if (log_pc.size() < 8) begin bad++; $display("FAIL rvredir_count got=%0d exp>=8", log_pc.size()); end
        for (int i = 0; i < log_pc.size(); i++) begin
            e = 32'h0000_0200 + 32'(4 * i);
            total++;
            if (log_pc[i] !== e || log_code[i] !== word_at(e))
            begin bad++; $display("FAIL rvredir_stream i=%0d got pc=%h exp pc=%h", i, log_pc[i], e); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        clear_log();
        tick();
        redirect = 1'b0;
        repeat (12) @(negedge clk);
        total++; if (log_pc.size() < 6) begin bad++; $display("FAIL wrap_count got=%0d exp>=6", log_pc.size()); end
        for (int i = 0; i < log_pc.size(); i++) begin
            e = 32'hFFFF_FFF8 + 32'(4 * i);
            total++;
            if (log_pc[i] !== e || log_code[i] !== word_at(e))
            begin bad++; $display("FAIL wrap_stream i=%0d got pc=%h exp pc=%h", i, log_pc[i], e); end
        end
    endtask

    task automatic test_random();
        logic [31:0] e;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_1000;
        clear_log();
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 300; k++) begin
            ready = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 3) == 0);
            lat   = $urandom_range(1, 3);
            tick();
        end
        ready = 1'b1;
        stall = 1'b0;
        lat = 1;
        repeat (20) tick();
        total++; if (log_pc.size() < 40) begin bad++; $display("FAIL random_count got=%0d exp>=40", log_pc.size()); end
        for (int i = 0; i < log_pc.size(); i++) begin
            e = 32'h0000_1000 + 32'(4 * i);
            total++;
            if (log_pc[i] !== e || log_code[i] !== word_at(e))
            begin bad++; $display("FAIL random_stream i=%0d got pc=%h code=%h exp pc=%h", i, log_pc[i], log_code[i], e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        tick();
        ready = 1'b0;
        repeat (10) tick();
        lat = 6;
        ready = 1'b1;
        tick();
        tick();
        ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (req !== 1'b0 || valid !== 1'b0 || code !== NOP || ipc !== 32'h0 || addr !== RST_PC)
        begin bad++; $display("FAIL midreset_outputs got req=%b v=%b code=%h pc=%h addr=%h", req, valid, code, ipc, addr); end
        repeat (2) @(negedge clk);
        lat = 1;
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        clear_log();
        @(negedge clk);
        total++;
        if (req !== 1'b1 || addr !== RST_PC)
        begin bad++; $display("FAIL midreset_refetch got req=%b addr=%h exp req=1 addr=%h", req, addr, RST_PC); end
        repeat (10) @(negedge clk);
        total++; if (log_pc.size() < 6) begin bad++; $display("FAIL midreset_count got=%0d exp>=6", log_pc.size()); end
        for (int i = 0; i < log_pc.size(); i++) begin
            e = RST_PC + 32'(4 * i);
            total++;
            if (log_pc[i] !== e || log_code[i] !== word_at(e))
            begin bad++; $display("FAIL midreset_stream i=%0d got pc=%h exp pc=%h", i, log_pc[i], e); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_ready_low();
        test_redirect();
        test_redirect_rvalid();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
